// File: rtl/sd_seq_ctrl_pkg.sv
// Shared definitions for the sequence-detector sequencing controller.
// Holds the FSM state encoding and the default parameter values used
// by the controller, its bus interface and its bit-period divider.
package sd_ctrl_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 4;
    localparam int DEF_DIV_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/sd_seq_ctrl_if.sv
// Host/detector-side bus of sd_seq_ctrl.
// Signals:
//   start, data, div    host request (start strobe, test word, bit-period divider)
//   sd_i, sd_o          serial link to the detector (to its input, from its output)
//   busy, done          run status (busy during SHIFT/DONE, one-cycle done pulse)
//   match_cnt, match_pos run results (saturating hit count, per-bit hit map)
// Modports:
//   master  the side that issues runs and models the detector
//   slave   the controller itself
interface sd_seq_ctrl_if
    import sd_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W,
    parameter int DIV_W = DEF_DIV_W
) ();

    logic             start;
    logic [WIDTH-1:0] data;
    logic [DIV_W-1:0] div;
    logic             sd_i;
    logic             sd_o;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] match_cnt;
    logic [WIDTH-1:0] match_pos;

    modport master (
        output start, data, div, sd_o,
        input  sd_i, busy, done, match_cnt, match_pos
    );

    modport slave (
        input  start, data, div, sd_o,
        output sd_i, busy, done, match_cnt, match_pos
    );

endinterface

// File: rtl/sd_seq_ctrl_bit_tick_gen.sv
// Bit-period divider for sd_seq_ctrl.
// A DIV_W down-counter that reloads from div and flags the last cycle of
// each period, so a period lasts div+1 clk cycles.
// Ports:
//   clk    system clock
//   reset  synchronous active-high reset, clears the count
//   clear  restart the period (count reloads from div)
//   div    period length minus one
//   tick   high in the last cycle of each period
module bit_tick_gen
    import sd_ctrl_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q;

    assign tick = (cnt_q == '0);

    // Counting down to zero means div=all-ones never has to represent
    // 2**DIV_W in the counter itself.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clear || tick) begin
            cnt_q <= div;
        end else begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

endmodule

// File: rtl/sd_seq_ctrl.sv
// Sequencing controller for the serial sequence-detector datapath.
// On an accepted start it latches a test word and a bit-period divider,
// shifts the word MSB-first onto sd_i (div+1 cycles per bit), samples the
// detector output sd_o in the last cycle of each bit period and reports a
// saturating match count, a per-bit match map and a one-cycle done pulse.
// Ports:
//   clk    system clock, all logic on posedge
//   reset  synchronous active-high reset (aborts a run, no done pulse)
//   bus    sd_seq_ctrl_if slave modport: start/data/div in, sd_i out,
//          sd_o in, busy/done/match_cnt/match_pos out
module sd_seq_ctrl
    import sd_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W,
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic          clk,
    input  logic          reset,
    sd_seq_ctrl_if.slave  bus
);

    localparam int IDX_W = $clog2(WIDTH);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] data_q;
    logic [DIV_W-1:0] div_q;
    logic [IDX_W-1:0] idx_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] pos_q;
    logic [DIV_W-1:0] div_sel;
    logic             tick;
    logic             accept;
    logic             sd_i_c;
    logic             busy_c;
    logic             done_c;

    assign accept = (state_q == IDLE) && bus.start;

    // Outside SHIFT the divider keeps reloading from the live div input, so
    // the first period of a run already uses the value latched with start.
    assign div_sel = (state_q == SHIFT) ? div_q : bus.div;

    bit_tick_gen #(
        .DIV_W (DIV_W)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .clear (state_q != SHIFT),
        .div   (div_sel),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = SHIFT;
            SHIFT:   if (tick && (idx_q == '0)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sd_i_c = 1'b1;
        busy_c = 1'b0;
        done_c = 1'b0;
        case (state_q)
            SHIFT: begin
                sd_i_c = data_q[idx_q];
                busy_c = 1'b1;
            end
            DONE: begin
                busy_c = 1'b1;
                done_c = 1'b1;
            end
            default: ;
        endcase
    end

    // Results are only touched by an accepted start or a sampled bit, so
    // they hold after done until the next run.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
            div_q  <= '0;
            idx_q  <= '0;
            cnt_q  <= '0;
            pos_q  <= '0;
        end else if (accept) begin
            data_q <= bus.data;
            div_q  <= bus.div;
            idx_q  <= IDX_W'(WIDTH - 1);
            cnt_q  <= '0;
            pos_q  <= '0;
        end else if ((state_q == SHIFT) && tick) begin
            if (bus.sd_o) begin
                pos_q[idx_q] <= 1'b1;
                if (cnt_q != '1) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
            if (idx_q != '0) begin
                idx_q <= idx_q - 1'b1;
            end
        end
    end

    assign bus.sd_i      = sd_i_c;
    assign bus.busy      = busy_c;
    assign bus.done      = done_c;
    assign bus.match_cnt = cnt_q;
    assign bus.match_pos = pos_q;

endmodule
